// File: rtl/bip_pkg.sv
// bip_pkg: shared encodings for the BIP1 control unit.
//   OP_*   : 5-bit opcodes (HLT..SUBI); all other opcodes decode as an illegal NOP
//   SELA_* : accumulator source selects
//   state_t: RUN/HALT machine state
//   ctrl_t : decoded control word driven by bip_decoder
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LDV  = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: purely combinational opcode -> control word for the BIP1 CPU.
//   i_opcode : instruction[15:11]
//   o_ctrl   : SelA/SelB/op/WrAcc/WrRam/RdRam plus illegal-opcode flag (ungated)
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] i_opcode,
    output ctrl_t      o_ctrl
);

    // Don't-care selects are driven 0 so unused fields stay quiet.
    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_HLT:  o_ctrl = '0;
            OP_STO:  o_ctrl.wr_ram = 1'b1;
            OP_LDV:  begin o_ctrl.sel_a = SELA_MEM; o_ctrl.wr_acc = 1'b1; o_ctrl.rd_ram = 1'b1; end
            OP_LDI:  begin o_ctrl.sel_a = SELA_IMM; o_ctrl.wr_acc = 1'b1; end
            OP_ADD:  begin o_ctrl.sel_a = SELA_ALU; o_ctrl.wr_acc = 1'b1; o_ctrl.rd_ram = 1'b1; end
            OP_ADDI: begin o_ctrl.sel_a = SELA_ALU; o_ctrl.sel_b = 1'b1; o_ctrl.wr_acc = 1'b1; end
            OP_SUB:  begin o_ctrl.sel_a = SELA_ALU; o_ctrl.op = 1'b1; o_ctrl.wr_acc = 1'b1; o_ctrl.rd_ram = 1'b1; end
            OP_SUBI: begin o_ctrl.sel_a = SELA_ALU; o_ctrl.sel_b = 1'b1; o_ctrl.op = 1'b1; o_ctrl.wr_acc = 1'b1; end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// bip_control: BIP1 control unit -- program counter, RUN/HALT FSM, executed-cycle
// counter and enable/halt gating of the decoded control word.
//   i_clk, i_rst (async, active-low), i_enable (0 = stall)
//   i_instruction : program memory data at o_addr_pm
//   o_addr_pm     : program counter
//   o_SelA/o_SelB/o_WrAcc/o_op : datapath controls
//   o_WrRam/o_RdRam           : data memory strobes
//   o_operand     : instruction[10:0]
//   o_halt, o_illegal, o_cycles : status
module bip_control
    import bip_pkg::*;
#(
    parameter int NB_DATA    = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADDR    = 11,
    parameter int NB_CYCLES  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [NB_DATA-1:0]    i_instruction,
    output logic [NB_ADDR-1:0]    o_addr_pm,
    output logic [1:0]            o_SelA,
    output logic                  o_SelB,
    output logic                  o_WrAcc,
    output logic                  o_op,
    output logic                  o_WrRam,
    output logic                  o_RdRam,
    output logic [NB_OPERAND-1:0] o_operand,
    output logic                  o_halt,
    output logic                  o_illegal,
    output logic [NB_CYCLES-1:0]  o_cycles
);

    state_t                r_state;
    state_t                w_next_state;
    logic [NB_ADDR-1:0]    r_pc;
    logic [NB_CYCLES-1:0]  r_cycles;
    ctrl_t                 w_ctrl;
    logic [NB_OPCODE-1:0]  w_opcode;
    logic                  w_exec;
    logic                  w_is_hlt;

    assign w_opcode = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign w_is_hlt = w_opcode == OP_HLT;
    assign w_exec   = (r_state == ST_RUN) && i_enable;

    bip_decoder u_decoder (
        .i_opcode (w_opcode),
        .o_ctrl   (w_ctrl)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= ST_RUN;
        else
            r_state <= w_next_state;
    end

    // HALT is terminal; only reset leaves it.
    always_comb begin
        w_next_state = (w_exec && w_is_hlt) ? ST_HALT : r_state;
    end

    // The HLT cycle itself is counted but does not advance the PC.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc     <= '0;
            r_cycles <= '0;
        end else if (w_exec) begin
            if (!w_is_hlt)
                r_pc <= r_pc + 1'b1;
            if (r_cycles != '1)
                r_cycles <= r_cycles + 1'b1;
        end
    end

    // Strobes also fall with i_rst so they drop the moment reset asserts,
    // regardless of what the instruction at address 0 decodes to.
    always_comb begin
        o_addr_pm = r_pc;
        o_SelA    = w_ctrl.sel_a;
        o_SelB    = w_ctrl.sel_b;
        o_op      = w_ctrl.op;
        o_WrAcc   = w_ctrl.wr_acc & w_exec & i_rst;
        o_WrRam   = w_ctrl.wr_ram & w_exec & i_rst;
        o_RdRam   = w_ctrl.rd_ram & w_exec & i_rst;
        o_operand = i_instruction[NB_OPERAND-1:0];
        o_halt    = r_state == ST_HALT;
        o_illegal = w_ctrl.illegal;
        o_cycles  = r_cycles;
    end

endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: self-checking bench for bip_control (decode vectors, program run,
// stall, illegal opcode, HLT under stall, async reset, PC wrap).
module tb_bip_control;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_enable = 1'b0;
    logic [15:0] i_instruction;
    logic [10:0] o_addr_pm;
    logic [1:0]  o_SelA;
    logic        o_SelB, o_WrAcc, o_op, o_WrRam, o_RdRam, o_halt, o_illegal;
    logic [10:0] o_operand;
    logic [31:0] o_cycles;

    logic [15:0] mem [0:2047];
    assign i_instruction = mem[o_addr_pm];

    always #5 i_clk = ~i_clk;

    bip_control dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_instruction(i_instruction),
        .o_addr_pm(o_addr_pm), .o_SelA(o_SelA), .o_SelB(o_SelB), .o_WrAcc(o_WrAcc),
        .o_op(o_op), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam), .o_operand(o_operand),
        .o_halt(o_halt), .o_illegal(o_illegal), .o_cycles(o_cycles)
    );

    localparam logic [15:0] NOP = {5'b01000, 11'd0};

    int n_pass = 0;
    int n_total = 0;

    logic [10:0] m_pc;
    logic        m_halt;
    logic [31:0] m_cycles;

    typedef struct {
        string       name;
        logic [62:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [15:0] instr;
        logic        en;
        logic [1:0]  sela;
        logic        selb, op, wa, wr, rr, ill;
    } tv_t;
    tv_t tv[13];

    // {sela[1:0], selb, op, wracc, wrram, rdram, illegal}
    function automatic logic [7:0] dec(input logic [4:0] opc);
        case (opc)
            5'd0:    return 8'b00_0_0_0_0_0_0;
            5'd1:    return 8'b00_0_0_0_1_0_0;
            5'd2:    return 8'b00_0_0_1_0_1_0;
            5'd3:    return 8'b01_0_0_1_0_0_0;
            5'd4:    return 8'b10_0_0_1_0_1_0;
            5'd5:    return 8'b10_1_0_1_0_0_0;
            5'd6:    return 8'b10_0_1_1_0_1_0;
            5'd7:    return 8'b10_1_1_1_0_0_0;
            default: return 8'b00_0_0_0_0_0_1;
        endcase
    endfunction

    function automatic logic [62:0] pack(input logic [10:0] pc, input logic [1:0] sa,
            input logic sb, input logic wa, input logic op, input logic wr, input logic rr,
            input logic [10:0] opd, input logic h, input logic ill, input logic [31:0] cyc);
        return {pc, sa, sb, wa, op, wr, rr, opd, h, ill, cyc};
    endfunction

    function automatic logic [62:0] actual();
        return pack(o_addr_pm, o_SelA, o_SelB, o_WrAcc, o_op, o_WrRam, o_RdRam,
                    o_operand, o_halt, o_illegal, o_cycles);
    endfunction

    function automatic logic [62:0] model_exp(input logic en);
        logic [7:0] d;
        logic       g;
        d = dec(mem[m_pc][15:11]);
        g = en && !m_halt;
        return pack(m_pc, d[7:6], d[5], d[3] & g, d[4], d[2] & g, d[1] & g,
                    mem[m_pc][10:0], m_halt, d[0], m_cycles);
    endfunction

    task automatic check(input string name, input logic [62:0] act, input logic [62:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic sb_pop_check();
        sb_t e;
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            check(e.name, actual(), e.exp);
        end
    endtask

    task automatic model_update(input logic en);
        if (!m_halt && en) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
            if (mem[m_pc][15:11] == 5'd0) m_halt = 1'b1;
            else m_pc++;
        end
    endtask

    // Called just after a rising edge; checks at the falling edge, advances the model.
    task automatic step(input string name, input logic en);
        i_enable = en;
        sbq.push_back('{name, model_exp(en)});
        @(negedge i_clk);
        sb_pop_check();
        @(posedge i_clk);
        model_update(en);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_enable = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        m_pc = '0;
        m_halt = 1'b0;
        m_cycles = '0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = NOP;
    endtask

    task automatic load_prog();
        clear_mem();
        mem[0] = {5'b00011, 11'd1};
        mem[1] = {5'b00100, 11'd3};
        mem[2] = {5'b00101, 11'd5};
        mem[3] = {5'b00110, 11'd7};
        mem[4] = {5'b00111, 11'd9};
        mem[5] = {5'b00001, 11'd2};
        mem[6] = {5'b00000, 11'd0};
    endtask

    initial begin
        tv[0]  = '{{5'd0, 11'd0},     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{{5'd1, 11'd2},     1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[2]  = '{{5'd2, 11'd100},   1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{{5'd3, 11'h7ff},   1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{{5'd4, 11'd3},     1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{{5'd5, 11'd5},     1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{{5'd6, 11'd7},     1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{{5'd7, 11'd9},     1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{{5'b01000, 11'd1}, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[9]  = '{{5'b11111, 11'h555}, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[10] = '{{5'b10101, 11'h2aa}, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{{5'd4, 11'd12},    1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[12] = '{{5'd2, 11'd13},    1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        clear_mem();

        // Decode vectors: one instruction at address 0 straight out of reset.
        foreach (tv[k]) begin
            clear_mem();
            mem[0] = tv[k].instr;
            do_reset();
            i_enable = tv[k].en;
            sbq.push_back('{$sformatf("vec%0d", k),
                pack(11'd0, tv[k].sela, tv[k].selb, tv[k].wa, tv[k].op, tv[k].wr, tv[k].rr,
                     tv[k].instr[10:0], 1'b0, tv[k].ill, 32'd0)});
            @(negedge i_clk);
            sb_pop_check();
            @(posedge i_clk);
            model_update(tv[k].en);
            #1;
            step($sformatf("vec%0d_next", k), 1'b1);
        end

        // Full program to HLT, then frozen.
        load_prog();
        do_reset();
        for (int i = 0; i < 7; i++) step($sformatf("prog%0d", i), 1'b1);
        for (int i = 0; i < 3; i++) step($sformatf("prog_halted%0d", i), 1'b1);
        check("prog_final", {52'd0, o_addr_pm, o_halt, o_cycles[7:0]}, {52'd0, 11'd6, 1'b1, 8'd7});

        // Stall at PC=2 (ADDI) for three cycles, then resume to HLT.
        do_reset();
        step("stall_pre0", 1'b1);
        step("stall_pre1", 1'b1);
        for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i), 1'b0);
        check("stall_hold", {52'd0, o_addr_pm}, {52'd0, 11'd2});
        for (int i = 0; i < 6; i++) step($sformatf("stall_resume%0d", i), 1'b1);

        // Illegal opcode at PC=0.
        clear_mem();
        mem[0] = {5'b01010, 11'h123};
        do_reset();
        step("illegal", 1'b1);
        check("illegal_pc", {52'd0, o_addr_pm}, {52'd0, 11'd1});

        // HLT while stalled stays RUN; HALT survives enable toggles.
        clear_mem();
        mem[0] = {5'd0, 11'd0};
        do_reset();
        step("hlt_stall0", 1'b0);
        step("hlt_stall1", 1'b0);
        step("hlt_go", 1'b1);
        step("hlt_tog0", 1'b0);
        step("hlt_tog1", 1'b1);
        step("hlt_tog2", 1'b0);
        step("hlt_tog3", 1'b1);

        // Async reset mid-run at PC=5 (LDV there so strobes are live before reset).
        clear_mem();
        mem[5] = {5'd2, 11'd9};
        do_reset();
        for (int i = 0; i < 5; i++) step($sformatf("rst_run%0d", i), 1'b1);
        i_enable = 1'b1;
        #2;
        check("pre_reset_rdram", {62'd0, o_RdRam}, {62'd0, 1'b1});
        i_rst = 1'b0;
        #1;
        check("async_reset", {15'd0, o_addr_pm, o_halt, o_cycles, o_WrAcc, o_WrRam, o_RdRam},
              {15'd0, 11'd0, 1'b0, 32'd0, 3'b000});
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        m_pc = '0;
        m_halt = 1'b0;
        m_cycles = '0;
        step("post_reset", 1'b1);

        // PC wrap over NOP-filled memory.
        clear_mem();
        do_reset();
        for (int i = 0; i < 2048; i++) step("wrap", 1'b1);
        check("wrap_end", {20'd0, o_addr_pm, o_cycles}, {20'd0, 11'd0, 32'd2048});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
